serial_add_ctrl: RTL and testbench

- Bit-serial add/subtract sequencer around one 1-bit FULL_ADDER instance.
- Loads two WIDTH-bit operands and feeds one bit pair per cycle, LSB first, through the adder. A carry flip-flop closes the loop between cycles.
- Delivers the WIDTH-bit result with carry-out and signed overflow flags.
- Serves as the low-area arithmetic path next to the parallel ripple adder in the ALU datapath.

---
 rtl/serial_add_ctrl_pkg.sv | 14 +
 rtl/serial_add_ctrl_full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 98 +++++++++
 tb/tb_serial_add_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// controller state encoding and the default datapath width.
package serial_add_ctrl_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module FULL_ADDER (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one operand bit pair per cycle, LSB first,
// through a single FULL_ADDER with a carry flip-flop closing the loop.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for START, outputs hold reset values
// ST_RUN  | one bit pair per edge through the adder, BUSY=1
// ST_DONE | R/CO/OV valid and held, DONE=1, START restarts
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SnA,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] R,
  output logic             CO,
  output logic             OV
);

  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             carry_msb;
  logic             co_q;
  logic             ov_q;
  logic             sum;
  logic             cout;

  FULL_ADDER u_fa (
    .A  (shift_a[0]),
    .B  (shift_b[0]),
    .CI (carry),
    .S  (sum),
    .CO (cout)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      shift_a   <= '0;
      shift_b   <= '0;
      res       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      co_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            shift_a <= A;
            shift_b <= SnA ? ~B : B;
            carry   <= SnA;
            cnt     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          res     <= {sum, res[WIDTH-1:1]};
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          carry   <= cout;
          cnt     <= cnt + CNT_W'(1);
          // carry out of bit WIDTH-2 is the carry into the MSB
          if (cnt == CNT_PEN) carry_msb <= cout;
          if (cnt == CNT_LAST) begin
            co_q  <= cout;
            ov_q  <= cout ^ carry_msb;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_DONE);
  assign R    = res;
  assign CO   = co_q;
  assign OV   = ov_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 with hand-computed results.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         START = 1'b0;
  logic         SnA = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] R;
  logic         CO;
  logic         OV;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SnA   (SnA),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .R     (R),
    .CO    (CO),
    .OV    (OV)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where DONE is first seen.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic hold_start, input logic scramble,
                       input logic [W-1:0] exp_r, input logic exp_co, input logic exp_ov);
    int busy_n;
    int guard;
    A = a; B = b; SnA = sub; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    if (!hold_start) START = 1'b0;
    check({tag, " accept_busy"}, 32'(BUSY), 32'd1);
    check({tag, " accept_done"}, 32'(DONE), 32'd0);
    busy_n = 0;
    guard = 0;
    while (!DONE && guard < 40) begin
      if (BUSY) busy_n++;
      if (scramble && busy_n == 3) begin
        A = ~A; B = 8'h5A; SnA = ~SnA;
      end
      guard++;
      @(negedge CLK);
    end
    START = 1'b0;
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(W));
    check({tag, " done"}, 32'(DONE), 32'd1);
    check({tag, " busy_off"}, 32'(BUSY), 32'd0);
    check({tag, " R"}, 32'(R), 32'(exp_r));
    check({tag, " CO"}, 32'(CO), 32'(exp_co));
    check({tag, " OV"}, 32'(OV), 32'(exp_ov));
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst BUSY", 32'(BUSY), 32'd0);
    check("rst DONE", 32'(DONE), 32'd0);
    check("rst R", 32'(R), 32'd0);
    check("rst CO", 32'(CO), 32'd0);
    check("rst OV", 32'(OV), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("idle state", 32'({BUSY, DONE}), 32'd0);
    end

    do_op("add", 8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    repeat (3) @(negedge CLK);
    check("done hold", 32'({DONE, R, CO, OV}), 32'({1'b1, 8'h96, 1'b0, 1'b1}));

    do_op("sub1", 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0);
    do_op("sub2", 8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1);
    do_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    // back-to-back: restart in the same cycle DONE is high
    do_op("b2b", 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

    // asynchronous reset in the middle of a run, away from any clock edge
    A = 8'hFF; B = 8'h00; SnA = 1'b0; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("arst BUSY", 32'(BUSY), 32'd0);
    check("arst DONE", 32'(DONE), 32'd0);
    check("arst R", 32'(R), 32'd0);
    check("arst CO", 32'(CO), 32'd0);
    check("arst OV", 32'(OV), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("post arst idle", 32'({BUSY, DONE}), 32'd0);
    do_op("fresh", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
